// File: rtl/matmul_sequencer_pkg.sv
// Shared types and sizing for the matmul instruction sequencer.
// Build option: define PERF_COUNTER_EN to get the busy-cycle counter in matmul_sequencer.
package matmul_sequencer_pkg;

  localparam int NU_COUNT     = 4;
  localparam int XY_MEM_DEPTH = 8;
  localparam int W_MEM_DEPTH  = 10;
  localparam int LENGTH_DEPTH = 8;
  localparam int SEL_W        = $clog2(NU_COUNT);

  typedef enum logic [1:0] {
    INST_NOP     = 2'd0,
    INST_FORWARD = 2'd1,
    INST_HALT    = 2'd2
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    WRITE,
    HALTED
  } seq_state_t;

  // Index of the last output written; only meaningful when length1 != 0.
  function automatic logic [SEL_W-1:0] write_last_idx(input logic [LENGTH_DEPTH-1:0] length1);
    return (length1 >= LENGTH_DEPTH'(NU_COUNT)) ? SEL_W'(NU_COUNT - 1) : SEL_W'(length1 - 1'b1);
  endfunction

endpackage

// File: rtl/seq_addr_counter.sv
// Loadable base+offset address counter; last flags the offset equal to the loaded terminal index.
// CW must not exceed AW.
module seq_addr_counter #(
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] last_idx,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] offset,
  output logic          last
);

  logic [AW-1:0] base_q;
  logic [CW-1:0] last_q;
  logic [CW-1:0] offset_q;

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      last_q   <= '0;
      offset_q <= '0;
    end else if (load) begin
      base_q   <= base;
      last_q   <= last_idx;
      offset_q <= '0;
    end else if (step) begin
      offset_q <= offset_q + 1'b1;
    end
  end

  assign addr   = base_q + AW'(offset_q);
  assign offset = offset_q;
  assign last   = (offset_q == last_q);

endmodule

// File: rtl/matmul_sequencer.sv
// Instruction responder driving xy/w memory addresses and MAC controls for FORWARD/HALT.
// Build option: PERF_COUNTER_EN adds a saturating count of busy cycles on perf_busy_cycles.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inst_valid,
  output logic                    inst_ready,
  input  logic [1:0]              inst_opcode,
  input  logic [XY_MEM_DEPTH-1:0] inst_x_addr,
  input  logic [XY_MEM_DEPTH-1:0] inst_y_addr,
  input  logic [W_MEM_DEPTH-1:0]  inst_w_addr,
  input  logic [LENGTH_DEPTH-1:0] inst_length0,
  input  logic [LENGTH_DEPTH-1:0] inst_length1,
  output logic [XY_MEM_DEPTH-1:0] xy_read_addr,
  output logic [W_MEM_DEPTH-1:0]  w_read_addr,
  output logic                    mac_clear,
  output logic                    mac_acc_en,
  output logic [XY_MEM_DEPTH-1:0] xy_write_addr,
  output logic                    xy_write_en,
  output logic [SEL_W-1:0]        mac_sel,
  output logic                    busy,
  output logic                    halted,
  output logic                    done,
  output logic                    len_err,
  output logic [31:0]             perf_busy_cycles
);

  seq_state_t state_q, state_d;
  opcode_t    opcode;
  logic       accept, load_fwd, fwd_end;
  logic       rd_step, rd_last, rd_active, wr_last;
  logic       rd_zero_q, wr_zero_q, done_q, len_err_q;
  logic [W_MEM_DEPTH-1:0]  w_base_q;
  logic [LENGTH_DEPTH-1:0] rd_offset;
  logic [XY_MEM_DEPTH-1:0] rd_addr, wr_addr;
  logic [SEL_W-1:0]        wr_offset;

  assign opcode   = opcode_t'(inst_opcode);
  assign accept   = inst_valid && (state_q == IDLE);
  assign load_fwd = accept && (opcode == INST_FORWARD);

  // The read stream's offset also indexes the weight memory, so one counter serves both.
  seq_addr_counter #(.AW(XY_MEM_DEPTH), .CW(LENGTH_DEPTH)) u_rd_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_fwd),
    .step     (rd_step),
    .base     (inst_x_addr),
    .last_idx (inst_length0 - 1'b1),
    .addr     (rd_addr),
    .offset   (rd_offset),
    .last     (rd_last)
  );

  seq_addr_counter #(.AW(XY_MEM_DEPTH), .CW(SEL_W)) u_wr_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_fwd),
    .step     (state_q == WRITE),
    .base     (inst_y_addr),
    .last_idx (write_last_idx(inst_length1)),
    .addr     (wr_addr),
    .offset   (wr_offset),
    .last     (wr_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      w_base_q  <= '0;
      rd_zero_q <= 1'b0;
      wr_zero_q <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fwd_end;
      if (load_fwd) begin
        w_base_q  <= inst_w_addr;
        rd_zero_q <= (inst_length0 == '0);
        wr_zero_q <= (inst_length1 == '0);
        if (inst_length1 > LENGTH_DEPTH'(NU_COUNT)) len_err_q <= 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    fwd_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (opcode)
            INST_FORWARD: state_d = CLEAR;
            INST_HALT:    state_d = HALTED;
            default:      state_d = IDLE;
          endcase
        end
      end
      CLEAR: begin
        // The clear cycle also presents the first read address.
        if (!rd_zero_q)     state_d = rd_last ? DRAIN : ACCUM;
        else if (wr_zero_q) begin state_d = IDLE; fwd_end = 1'b1; end
        else                state_d = WRITE;
      end
      ACCUM: if (rd_last) state_d = DRAIN;
      DRAIN: begin
        if (wr_zero_q) begin state_d = IDLE; fwd_end = 1'b1; end
        else           state_d = WRITE;
      end
      WRITE: if (wr_last) begin state_d = IDLE; fwd_end = 1'b1; end
      default: state_d = state_q;
    endcase
  end

  assign rd_step   = (state_q == CLEAR) || (state_q == ACCUM);
  assign rd_active = ((state_q == CLEAR) && !rd_zero_q) || (state_q == ACCUM);

  assign inst_ready    = (state_q == IDLE);
  assign busy          = (state_q != IDLE) && (state_q != HALTED);
  assign halted        = (state_q == HALTED);
  assign done          = done_q;
  assign len_err       = len_err_q;
  assign mac_clear     = (state_q == CLEAR);
  assign mac_acc_en    = (state_q == ACCUM) || (state_q == DRAIN);
  assign xy_read_addr  = rd_active ? rd_addr : '0;
  assign w_read_addr   = rd_active ? (w_base_q + W_MEM_DEPTH'(rd_offset)) : '0;
  assign xy_write_en   = (state_q == WRITE);
  assign xy_write_addr = xy_write_en ? wr_addr : '0;
  assign mac_sel       = xy_write_en ? wr_offset : '0;

`ifdef PERF_COUNTER_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     perf_q <= '0;
    else if (busy && perf_q != '1) perf_q <= perf_q + 1'b1;
  end

  assign perf_busy_cycles = perf_q;
`else
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a per-instruction cycle model feeds a queue that a monitor drains.
module tb_matmul_sequencer;
  import matmul_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [1:0]  inst_opcode = 2'd0;
  logic [7:0]  inst_x_addr = '0, inst_y_addr = '0;
  logic [9:0]  inst_w_addr = '0;
  logic [7:0]  inst_length0 = '0, inst_length1 = '0;
  logic [7:0]  xy_read_addr, xy_write_addr;
  logic [9:0]  w_read_addr;
  logic        mac_clear, mac_acc_en, xy_write_en, busy, halted, done, len_err;
  logic [1:0]  mac_sel;
  logic [31:0] perf_busy_cycles;

  matmul_sequencer dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_opcode(inst_opcode), .inst_x_addr(inst_x_addr), .inst_y_addr(inst_y_addr),
    .inst_w_addr(inst_w_addr), .inst_length0(inst_length0), .inst_length1(inst_length1),
    .xy_read_addr(xy_read_addr), .w_read_addr(w_read_addr), .mac_clear(mac_clear),
    .mac_acc_en(mac_acc_en), .xy_write_addr(xy_write_addr), .xy_write_en(xy_write_en),
    .mac_sel(mac_sel), .busy(busy), .halted(halted), .done(done), .len_err(len_err),
    .perf_busy_cycles(perf_busy_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       inst_ready, busy, halted, done, len_err, mac_clear, mac_acc_en, xy_write_en;
    logic [7:0] xy_read_addr;
    logic [9:0] w_read_addr;
    logic [7:0] xy_write_addr;
    logic [1:0] mac_sel;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_busy = 0;
  bit   exp_halted = 1'b0;
  bit   exp_len_err = 1'b0;

  function automatic obs_t sample();
    obs_t a;
    a.inst_ready = inst_ready;  a.busy = busy;  a.halted = halted;  a.done = done;
    a.len_err = len_err;  a.mac_clear = mac_clear;  a.mac_acc_en = mac_acc_en;
    a.xy_write_en = xy_write_en;  a.xy_read_addr = xy_read_addr;  a.w_read_addr = w_read_addr;
    a.xy_write_addr = xy_write_addr;  a.mac_sel = mac_sel;
    return a;
  endfunction

  function automatic obs_t quiet_vec();
    obs_t v = '0;
    v.inst_ready = !exp_halted;
    v.halted     = exp_halted;
    v.len_err    = exp_len_err;
    return v;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @%0t: actual=%p required=%p", name, $time, act, req);
    end
  endtask

  // Reference: cycle k=1 clears, reads run k=1..l0, accumulates k=2..l0+1,
  // writes follow (after a drain when l0>0), and the final cycle is done.
  task automatic push_forward(input logic [7:0] x, y, input logic [9:0] w, input int l0, l1);
    int l1c   = (l1 > NU_COUNT) ? NU_COUNT : l1;
    int wbase = (l0 > 0) ? l0 + 2 : 2;
    int n     = wbase + l1c;
    for (int k = 1; k <= n; k++) begin
      obs_t v = '0;
      v.len_err    = exp_len_err;
      v.busy       = (k < n);
      v.inst_ready = (k == n);
      v.done       = (k == n);
      v.mac_clear  = (k == 1);
      v.mac_acc_en = (k >= 2) && (k <= l0 + 1);
      if (k <= l0) begin
        v.xy_read_addr = 8'(int'(x) + k - 1);
        v.w_read_addr  = 10'(int'(w) + k - 1);
      end
      if (k >= wbase && k < n) begin
        v.xy_write_en   = 1'b1;
        v.xy_write_addr = 8'(int'(y) + k - wbase);
        v.mac_sel       = 2'(k - wbase);
      end
      exp_q.push_back(v);
    end
  endtask

  // Monitor: one comparison per cycle, on the falling edge.
  initial begin
    forever begin
      obs_t e;
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : quiet_vec();
      if (e.busy) exp_busy++;
      check("cycle", sample(), e);
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] x, y, input logic [9:0] w,
                      input logic [7:0] l0, l1, input bit expect_accept, input int budget);
    bit rdy, acc;
    acc = 1'b0;
    inst_opcode = op;  inst_x_addr = x;  inst_y_addr = y;  inst_w_addr = w;
    inst_length0 = l0;  inst_length1 = l1;  inst_valid = 1'b1;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge clk);
      rdy = inst_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = 1'b1;
    end
    inst_valid = 1'b0;
    if (acc && op == INST_FORWARD) begin
      if (l1 > NU_COUNT) exp_len_err = 1'b1;
      push_forward(x, y, w, int'(l0), int'(l1));
    end else if (acc && op == INST_HALT) begin
      exp_halted = 1'b1;
    end
    vectors++;
    if (acc != expect_accept) begin
      miscompares++;
      $display("FAIL accept op=%0d: actual=%0d required=%0d", op, acc, expect_accept);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_halted  = 1'b0;
    exp_len_err = 1'b0;
    exp_busy    = 0;
    #1;
    check("async_reset", sample(), quiet_vec());
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain_queue();
    for (int c = 0; c < 600 && exp_q.size() != 0; c++) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    repeat (2) @(posedge clk);
    #1;

    // Directed cases
    send(INST_FORWARD, 8'd2,   8'd0,   10'd12,   8'd4, 8'd2, 1'b1, 300);
    send(INST_FORWARD, 8'd10,  8'd20,  10'd100,  8'd0, 8'd3, 1'b1, 300);
    send(INST_FORWARD, 8'd255, 8'd7,   10'd1023, 8'd3, 8'd1, 1'b1, 300);
    send(INST_FORWARD, 8'd5,   8'd0,   10'd0,    8'd1, 8'd0, 1'b1, 300);
    send(INST_FORWARD, 8'd9,   8'd9,   10'd9,    8'd0, 8'd0, 1'b1, 300);
    send(INST_NOP,     8'd1,   8'd1,   10'd1,    8'd1, 8'd1, 1'b1, 300);
    send(2'd3,         8'd1,   8'd1,   10'd1,    8'd1, 8'd1, 1'b1, 300);
    send(INST_FORWARD, 8'd40,  8'd254, 10'd500,  8'd2, 8'd6, 1'b1, 300);
    send(INST_FORWARD, 8'd41,  8'd30,  10'd501,  8'd2, 8'd4, 1'b1, 300);
    drain_queue();

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] op = (r < 8) ? INST_FORWARD : ((r == 8) ? INST_NOP : 2'd3);
      send(op, 8'($urandom), 8'($urandom), 10'($urandom),
           8'($urandom_range(0, 8)), 8'($urandom_range(0, 6)), 1'b1, 300);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
    end
    drain_queue();

    // FORWARD then HALT with valid held; later FORWARDs must be refused
    send(INST_FORWARD, 8'd3, 8'd100, 10'd7, 8'd3, 8'd2, 1'b1, 300);
    send(INST_HALT,    8'd0, 8'd0,   10'd0, 8'd0, 8'd0, 1'b1, 300);
    send(INST_FORWARD, 8'd4, 8'd4,   10'd4, 8'd2, 8'd2, 1'b0, 20);
    drain_queue();

    do_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of ACCUM: outputs drop at once, no writes follow
    send(INST_FORWARD, 8'd60, 8'd70, 10'd80, 8'd10, 8'd3, 1'b1, 300);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;

    send(INST_FORWARD, 8'd200, 8'd201, 10'd202, 8'd2, 8'd2, 1'b1, 300);
    drain_queue();

`ifdef PERF_COUNTER_EN
    vectors++;
    if (perf_busy_cycles !== 32'(exp_busy)) begin
      miscompares++;
      $display("FAIL perf_busy_cycles: actual=%0d required=%0d", perf_busy_cycles, exp_busy);
    end
`else
    vectors++;
    if (perf_busy_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_busy_cycles: actual=%0d required=0", perf_busy_cycles);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Instruction responder and sequencer for the NeuralNetwork datapath, i.e. the consumer side of the controller instruction interface.
- Accepts one instruction per valid/ready handshake: FORWARD (x, y, w addresses plus length0/length1) or HALT.
- For FORWARD, drives the xy/w memory read addresses and the MAC accumulate enables for length0 cycles, then the xy write port and MAC output select for length1 cycles.
- Sits between the instruction source (host or bench) and the mac_gen array plus xy/w memories.

Parameters:
NU_COUNT, 4, number of MAC units; bounds length1.
XY_MEM_DEPTH, 8, xy memory address width.
W_MEM_DEPTH, 10, w memory address width.
LENGTH_DEPTH, 8, width of length0/length1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_valid  in  1  instruction offered
inst_ready  out  1  sequencer can accept
inst_opcode  in  2  opcode_t (NOP/FORWARD/HALT)
inst_x_addr  in  XY_MEM_DEPTH  input vector base
inst_y_addr  in  XY_MEM_DEPTH  output vector base
inst_w_addr  in  W_MEM_DEPTH  weight base
inst_length0  in  LENGTH_DEPTH  accumulate cycles
inst_length1  in  LENGTH_DEPTH  outputs to write
xy_read_addr  out  XY_MEM_DEPTH  xy memory read address
w_read_addr  out  W_MEM_DEPTH  w memory read address
mac_clear  out  1  clear all MAC accumulators
mac_acc_en  out  1  MACs accumulate this cycle
xy_write_addr  out  XY_MEM_DEPTH  xy memory write address
xy_write_en  out  1  write strobe
mac_sel  out  $clog2(NU_COUNT)  MAC whose mac_reg drives the write data
busy  out  1  high when state is not IDLE or HALTED
halted  out  1  HALT executed
done  out  1  one-cycle pulse at the end of a FORWARD
len_err  out  1  sticky: length1 > NU_COUNT was seen
perf_busy_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except inst_ready=1.
- Reset asserted mid-operation aborts the operation; no further writes occur.
- Handshake: an instruction is accepted on a rising clk edge with inst_valid && inst_ready. inst_ready=1 only in IDLE.
- Operands are registered at acceptance and ignored thereafter.
- NOP and unknown opcodes: accepted, no effect, remain IDLE.
- HALT: go to HALTED. inst_ready=0 and halted=1 until reset.
- FORWARD at accept edge T: mac_clear=1 during cycle T+1.
- ACCUM state, i = 0..length0-1, cycle T+1+i:
  - xy_read_addr = x + i, w_read_addr = w + i (wrapping at the address width).
  - Memory read latency is 1, so mac_acc_en is high in cycles T+2 .. T+1+length0.
- DRAIN state: one cycle covering the last accumulate.
- WRITE state, j = 0..L1-1 with L1 = min(length1, NU_COUNT):
  - xy_write_en=1, xy_write_addr = y + j (wrapping), mac_sel = j.
  - length1 > NU_COUNT sets len_err.
- done pulses in the cycle after the last write, with the return to IDLE.
- Zero lengths:
  - length0=0: ACCUM and DRAIN are skipped; the mac_clear cycle is followed directly by WRITE.
  - length1=0: no writes; done follows DRAIN.
  - length0=0 and length1=0: clear cycle, then done.
- Address counters are registered, not combinational from inputs.
- Outputs hold 0 when not in their active state.
- Read and write may target overlapping addresses. Writes occur strictly after all reads, so no hazard logic is needed.

Optional Feature:
PERF_COUNTER_EN defined:
- perf_busy_cycles is a 32-bit saturating counter of cycles with busy=1.
- Cleared by reset only.
Not defined:
- perf_busy_cycles is tied to 0 and no counter is synthesised.

Decomposition:
- Package definitions: opcode_t enum (INST_NOP=0, INST_FORWARD=1, INST_HALT=2), seq_state_t enum (IDLE, CLEAR, ACCUM, DRAIN, WRITE, HALTED), and the shared NU_COUNT/XY_MEM_DEPTH/W_MEM_DEPTH/LENGTH_DEPTH constants.
- One natural sub-module, seq_addr_counter: loadable base+offset counter with a terminal-count flag, instantiated for the read and write address streams.

Test Plan:
- FORWARD x=2, y=0, w=12, length0=4, length1=2, accepted at T:
  - mac_clear at T+1.
  - Read addresses xy 2,3,4,5 and w 12,13,14,15 in T+1..T+4.
  - mac_acc_en high T+2..T+5.
  - Writes at xy 0 (sel 0) and xy 1 (sel 1) in T+6..T+7.
  - done at T+8, inst_ready=1 again at T+8.
- FORWARD then HALT back-to-back with inst_valid held: HALT is accepted only after done. halted=1 thereafter, and a further FORWARD is never accepted.
- length0=0, length1=3: no mac_acc_en; writes at y..y+2 immediately after the clear cycle.
- length1=6 with NU_COUNT=4: exactly 4 writes; len_err=1 and it stays set.
- x=255, length0=3 with XY_MEM_DEPTH=8: read addresses 255, 0, 1.
- Reset pulsed during ACCUM: all outputs 0 immediately, inst_ready=1, no writes issued afterwards.
